sqrt2_bus_ctrl: RTL

Host-side sequencer that sits directly upstream of the FP16 square-root unit `sqrt2`. It takes binary16 operands over a valid/ready stream, runs the `sqrt2` shared-bus protocol, and returns the result and class flags over a second valid/ready stream. The protocol is: drive operand with ENABLE, release the bus, wait for RESULT, then capture. The block also adds a timeout so that a hung square-root unit cannot stall the pipeline.

---
 rtl/sqrt2_bus_ctrl_if.sv | 40 ++++
 rtl/sqrt2_bus_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sqrt2_bus_ctrl_if.sv
// Operand/result valid-ready streams of the sqrt2 host sequencer.
// master = producer/consumer side, slave = sequencer side.
interface sqrt2_bus_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_is_nan;
  logic        out_is_pinf;
  logic        out_is_ninf;
  logic        out_timeout;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_is_nan,
    input  out_is_pinf,
    input  out_is_ninf,
    input  out_timeout
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_is_nan,
    output out_is_pinf,
    output out_is_ninf,
    output out_timeout
  );
endinterface

// File: rtl/sqrt2_bus_ctrl.sv
// Host sequencer for the sqrt2 shared-bus FP16 square-root unit.
// Drives the operand for one cycle, waits for RESULT or a timeout.
module sqrt2_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 11,
  parameter logic [15:0] TIMEOUT_VALUE  = 16'h7E00
) (
  input  logic               clk_i,
  input  logic               rst_i,
  sqrt2_bus_ctrl_if.slave    s,
  inout  wire         [15:0] io_data_io,
  output logic               enable_o,
  input  logic               result_i,
  input  logic               is_nan_i,
  input  logic               is_pinf_i,
  input  logic               is_ninf_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  logic [15:0] op_q;
  logic [15:0] data_q;
  logic        nan_q;
  logic        pinf_q;
  logic        ninf_q;
  logic        to_q;
  logic        valid_q;
  logic        enable_q;
  logic        drive_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic        tmo_hit;

  assign cnt_d   = cnt_q + 1'b1;
  assign tmo_hit = (cnt_d == CNT_MAX);

  // Bus is owned by us only during the single DRIVE cycle.
  assign io_data_io = drive_q ? op_q : 16'hzzzz;

  assign enable_o      = enable_q;
  assign s.in_ready    = (state_q == IDLE);
  assign s.out_valid   = valid_q;
  assign s.out_data    = data_q;
  assign s.out_is_nan  = nan_q;
  assign s.out_is_pinf = pinf_q;
  assign s.out_is_ninf = ninf_q;
  assign s.out_timeout = to_q;

  // Sequencer FSM; RESULT takes priority over timeout in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      data_q   <= '0;
      nan_q    <= 1'b0;
      pinf_q   <= 1'b0;
      ninf_q   <= 1'b0;
      to_q     <= 1'b0;
      valid_q  <= 1'b0;
      enable_q <= 1'b0;
      drive_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s.in_valid) begin
            op_q     <= s.in_data;
            drive_q  <= 1'b1;
            enable_q <= 1'b1;
            state_q  <= DRIVE;
          end
        end
        DRIVE: begin
          drive_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (result_i) begin
            data_q   <= io_data_io;
            nan_q    <= is_nan_i;
            pinf_q   <= is_pinf_i;
            ninf_q   <= is_ninf_i;
            to_q     <= 1'b0;
            valid_q  <= 1'b1;
            enable_q <= 1'b0;
            state_q  <= DONE;
          end else if (tmo_hit) begin
            data_q   <= TIMEOUT_VALUE;
            nan_q    <= 1'b0;
            pinf_q   <= 1'b0;
            ninf_q   <= 1'b0;
            to_q     <= 1'b1;
            valid_q  <= 1'b1;
            enable_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          if (s.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
